// File: rtl/config_deserializer.sv
// Configuration bitstream deserializer.
// A serial frame arrives on prog_clk/head, asynchronous to clk:
//   [noise] SYNC(8) | N(LEN_W) | N words (WORD_W each) | XOR checksum (WORD_W)
// Each word is presented on cfg_data/cfg_addr with a valid/ready handshake.
// The frame ends in DONE (good checksum) or ERR (bad checksum or overflow).
//
// state | meaning
// IDLE  | disabled or just reset; waits for en
// HUNT  | sliding 8-bit window searching for the sync byte
// LEN   | shifting in the word count N
// DATA  | shifting in configuration words, presenting each one on completion
// CHECK | shifting in the checksum; the last word may still be pending
// DONE  | frame good, done held until en low
// ERR   | checksum mismatch or overflow, error held until en low
module config_deserializer #(
    parameter int         WORD_W = 32,
    parameter int         LEN_W  = 16,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              prog_clk,
    input  logic              head,
    output logic [WORD_W-1:0] cfg_data,
    output logic [LEN_W-1:0]  cfg_addr,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int MAX_W = (WORD_W > LEN_W) ? WORD_W : LEN_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HUNT  = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t state;
    state_t next_state;

    logic [1:0]        pclk_sync;
    logic [1:0]        head_sync;
    logic              pclk_prev;
    logic              bit_evt;
    logic              bit_val;

    logic [7:0]        win;
    logic [7:0]        win_next;
    logic [LEN_W-1:0]  len_sh;
    logic [LEN_W-1:0]  len_next;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  words_left;
    logic [WORD_W-1:0] acc;

    logic              field_end;
    logic              sync_hit;
    logic              accept;
    logic              stall;
    logic              last_word;

    // Two-flop synchronizers for the programming port, plus an edge-detect stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_sync <= '0;
            head_sync <= '0;
            pclk_prev <= 1'b0;
        end else begin
            pclk_sync <= {pclk_sync[0], prog_clk};
            head_sync <= {head_sync[0], head};
            pclk_prev <= pclk_sync[1];
        end
    end

    // A bit is taken on a falling edge of the synchronized programming clock.
    assign bit_evt   = pclk_prev & ~pclk_sync[1];
    assign bit_val   = head_sync[1];

    assign win_next  = {win[6:0], bit_val};
    assign len_next  = {len_sh[LEN_W-2:0], bit_val};
    assign word_next = {shreg[WORD_W-2:0], bit_val};

    // bit_cnt counts down; the field ends on the bit taken at terminal count zero.
    assign field_end = bit_evt && (bit_cnt == '0);
    assign sync_hit  = bit_evt && (win_next == SYNC);
    assign accept    = cfg_valid && cfg_ready;
    assign stall     = cfg_valid && !cfg_ready;
    assign last_word = (words_left == LEN_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; en low overrides everything and returns to IDLE.
    always_comb begin
        next_state = state;
        if (!en) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: next_state = S_HUNT;
                S_HUNT: begin
                    if (sync_hit) next_state = S_LEN;
                end
                S_LEN: begin
                    if (field_end) begin
                        next_state = (len_next == '0) ? S_CHECK : S_DATA;
                    end
                end
                S_DATA: begin
                    if (field_end) begin
                        if (stall)          next_state = S_ERR;
                        else if (last_word) next_state = S_CHECK;
                    end
                end
                S_CHECK: begin
                    // An unaccepted final word at checksum time is an overflow.
                    if (field_end) begin
                        if (stall || (word_next != acc)) next_state = S_ERR;
                        else                             next_state = S_DONE;
                    end
                end
                S_DONE:  next_state = S_DONE;
                S_ERR:   next_state = S_ERR;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Status flags are registered copies of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            busy  <= (next_state == S_HUNT) || (next_state == S_LEN) ||
                     (next_state == S_DATA) || (next_state == S_CHECK);
            done  <= (next_state == S_DONE);
            error <= (next_state == S_ERR);
        end
    end

    // Field shifting, word counting, checksum accumulation and the output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win        <= '0;
            len_sh     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            acc        <= '0;
            cfg_data   <= '0;
            cfg_addr   <= '0;
            cfg_valid  <= 1'b0;
        end else if (!en) begin
            win        <= '0;
            len_sh     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            words_left <= '0;
            acc        <= '0;
            cfg_data   <= '0;
            cfg_addr   <= '0;
            cfg_valid  <= 1'b0;
        end else begin
            // Acceptance is independent of the bit stream; it may land in DATA or CHECK.
            if (accept) begin
                cfg_valid <= 1'b0;
                cfg_addr  <= cfg_addr + LEN_W'(1);
            end

            case (state)
                S_IDLE: begin
                    win <= '0;
                end
                S_HUNT: begin
                    if (bit_evt) begin
                        win <= win_next;
                        if (win_next == SYNC) begin
                            bit_cnt <= CNT_W'(LEN_W - 1);
                        end
                    end
                end
                S_LEN: begin
                    if (bit_evt) begin
                        len_sh  <= len_next;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            bit_cnt    <= CNT_W'(WORD_W - 1);
                            words_left <= len_next;
                            cfg_addr   <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (bit_evt) begin
                        shreg   <= word_next;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            bit_cnt <= CNT_W'(WORD_W - 1);
                            if (stall) begin
                                // Collision: the pending word is dropped as we go to ERR.
                                cfg_valid <= 1'b0;
                            end else begin
                                cfg_data   <= word_next;
                                cfg_valid  <= 1'b1;
                                acc        <= acc ^ word_next;
                                words_left <= words_left - LEN_W'(1);
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (bit_evt) begin
                        shreg   <= word_next;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        if (bit_cnt == '0) begin
                            // Frame is over either way; nothing may stay pending.
                            cfg_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
